// File: rtl/led_fade_pwm_if.sv
// Pattern-in / LED-drive bundle between the rotator and the fade/PWM stage.
// No handshake: every signal is valid on every clock; pattern_in is sampled each cycle.
interface led_fade_pwm_if #(
  parameter int N_LEDS = 4
);
  logic              enable;
  logic [N_LEDS-1:0] pattern_in;
  logic [N_LEDS-1:0] led_out;
  logic              pwm_wrap;

  modport master (
    output enable,
    output pattern_in,
    input  led_out,
    input  pwm_wrap
  );

  modport slave (
    input  enable,
    input  pattern_in,
    output led_out,
    output pwm_wrap
  );
endinterface

// File: rtl/led_fade_pwm.sv
// Per-channel fade-out with shared PWM counter; lit channels run at full brightness.
// Optional macro LED_GAMMA_EN selects a gamma-2 duty curve instead of the linear one.
module led_fade_pwm #(
  parameter int N_LEDS    = 4,
  parameter int PWM_BITS  = 8,
  parameter int FADE_DIV  = 46875,
  parameter int FADE_STEP = 8
) (
  input logic           clk,
  input logic           rst,
  led_fade_pwm_if.slave bus
);

  localparam int                  MAX    = (1 << PWM_BITS) - 1;
  localparam int                  FC_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_V  = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] LAST_V = PWM_BITS'(MAX - 1);
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(FADE_STEP);
  localparam logic [FC_W-1:0]     FC_LAST = FC_W'(FADE_DIV - 1);

  logic [FC_W-1:0]     r_fade_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_level [N_LEDS];
  logic [PWM_BITS-1:0] r_duty  [N_LEDS];
  logic [N_LEDS-1:0]   r_led;
  logic                r_wrap;

  logic                w_fade_tick;
  logic                w_pwm_last;
  logic [PWM_BITS-1:0] w_decayed [N_LEDS];

  function automatic logic [PWM_BITS-1:0] f_shape(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_GAMMA_EN
    // l*(l+1) never exceeds 2^(2*PWM_BITS)-1, so the top half maps MAX to MAX.
    logic [2*PWM_BITS-1:0] sq;
    sq = ({{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl}) + {{PWM_BITS{1'b0}}, lvl};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return lvl;
`endif
  endfunction

  assign w_fade_tick = (r_fade_cnt == FC_LAST);
  assign w_pwm_last  = (r_pwm_cnt == LAST_V);

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      w_decayed[i] = '0;
      if (r_level[i] > STEP_V) w_decayed[i] = r_level[i] - STEP_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fade_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_led      <= '0;
      r_wrap     <= 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
        r_level[i] <= '0;
        r_duty[i]  <= '0;
      end
    end else if (!bus.enable) begin
      r_fade_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_led      <= '0;
      r_wrap     <= 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
        r_level[i] <= '0;
        r_duty[i]  <= '0;
      end
    end else begin
      r_fade_cnt <= w_fade_tick ? '0 : r_fade_cnt + 1'b1;
      r_pwm_cnt  <= w_pwm_last  ? '0 : r_pwm_cnt + 1'b1;
      r_wrap     <= (r_pwm_cnt == '0);
      for (int i = 0; i < N_LEDS; i++) begin
        // A lit pattern bit overrides a coincident fade tick.
        if (bus.pattern_in[i])  r_level[i] <= MAX_V;
        else if (w_fade_tick)   r_level[i] <= w_decayed[i];
        // Duty is latched only at the period boundary so a period is never split.
        if (w_pwm_last)         r_duty[i]  <= f_shape(r_level[i]);
        r_led[i] <= (r_pwm_cnt < r_duty[i]);
      end
    end
  end

  assign bus.led_out  = r_led;
  assign bus.pwm_wrap = r_wrap;

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the LED rotator on the Alchitry Cu board; consumes its N-bit LED pattern and drives the physical LED pins.
- Each lit channel is driven at full brightness. When a channel goes dark, it fades out linearly, which gives a comet-tail trail behind the rotating LED.
- Brightness is produced by a shared free-running PWM counter compared against a per-channel duty register.

Parameters:
- N_LEDS, 4, number of LED channels.
- PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS-1; PWM period = MAX cycles.
- FADE_DIV, 46875, clk cycles per fade tick (>=1).
- FADE_STEP, 8, level decrement per fade tick (1..MAX).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run; 0 = blank outputs and clear state.
- pattern_in  in  N_LEDS  LED pattern from the rotator (bit i = channel i).
- led_out  out  N_LEDS  registered PWM drive to the LED pins.
- pwm_wrap  out  1  one-cycle pulse marking the start of each PWM period.

Behaviour:
- Reset (async assert, sync-safe deassert): all levels, duties, pwm_cnt and fade_cnt are 0; led_out=0; pwm_wrap=0.
- enable=0: same clear state as reset (synchronous). Counters hold at 0, led_out=0, pwm_wrap=0.
- Fade tick generator: fade_cnt counts 0..FADE_DIV-1 and wraps; fade_tick=1 in the cycle fade_cnt==FADE_DIV-1.
- Per-channel level[i] (PWM_BITS wide), updated every cycle:
  - pattern_in[i]=1: level <= MAX, regardless of fade_tick. Set wins over decay.
  - pattern_in[i]=0 and fade_tick: level <= level-FADE_STEP, saturating at 0 (no wrap).
  - Otherwise level holds.
- PWM counter: pwm_cnt counts 0..MAX-1 and wraps, giving a period of MAX cycles.
- Duty shadowing:
  - duty[i] <= f(level[i]) only in the cycle pwm_cnt==MAX-1, so a new duty takes effect from pwm_cnt=0.
  - Duty never changes mid-period, so no glitch pulses.
- Output: led_out[i] <= (pwm_cnt < duty[i]), registered.
  - duty=MAX gives constant 1; duty=0 gives constant 0.
  - Latency: 1 cycle from pwm_cnt to led_out.
  - Pattern rising to first lit output: at most MAX+2 cycles.
- pwm_wrap <= (pwm_cnt==0), registered; aligned with the led_out cycle that reflects pwm_cnt=0.
- Channels are fully independent; any number may be lit or fading simultaneously.
- Reset or enable deassert mid-period: clears immediately; on resume, the first period starts at pwm_cnt=0 with duty=0.
- Widths: level/duty/pwm_cnt are PWM_BITS; fade_cnt is clog2(FADE_DIV) bits, min 1.

Optional Feature:
- Macro LED_GAMMA_EN.
- Defined: f(level) = (level*level + level) >> PWM_BITS, a 2*PWM_BITS-wide intermediate giving an approximate gamma-2 perceptual curve.
  - Maps f(0)=0 and f(MAX)=MAX.
  - Example, PWM_BITS=8: f(128)=64.
- Undefined: f(level) = level (linear), and no multiplier is synthesised.

Test Plan:
- Reset/blank, run with PWM_BITS=4, FADE_DIV=4, FADE_STEP=3 (MAX=15) for all remaining cases: assert rst mid-run -> led_out=0 and pwm_wrap=0 immediately (async). Deassert with enable=1 and pattern=0 -> led_out stays 0 and pwm_wrap pulses every 15 cycles.
- Full on: pattern_in=4'b0001 held -> from the second period onward, led_out[0]=1 on all 15 cycles per period; led_out[3:1]=0.
- Decay: hold 4'b0001, then drop to 0 -> level[0] steps 15,12,9,6,3,0 on successive fade ticks (4 cycles apart). Each period's high time equals the duty latched at that period's start; never negative or wrapped.
- Set/tick collision: pattern bit rises in the same cycle as fade_tick -> level=15, not 12.
- Rotation: pattern 0001→0010→0100→1000, changing every 20 cycles -> current LED at duty 15 and the previous LED decaying. A duty change is never observed mid-period (check at pwm_wrap boundaries).
- LED_GAMMA_EN defined, PWM_BITS=8: level 128 -> 64 high cycles per 255-cycle period; level 255 -> 255 (always on); level 0 -> 0.
